if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2: fetch-queue entries; legal values are 2 and 4.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-005 stall  input  1: decode cannot accept; when 1, the queue head is not consumed.
REQ-006 branch_flag  input  1: redirect request from execute.
REQ-007 branch_target_address  input  32: redirect PC.
REQ-008 rom_inst  input  32: instruction word returned combinationally by the instruction ROM, already byte-swapped.
REQ-009 rom_ce  output  1: ROM chip enable (1 = enable).
REQ-010 rom_addr  output  32: byte address to the ROM.
REQ-011 if_valid  output  1: if_pc/if_inst hold a valid instruction.
REQ-012 if_pc  output  32: PC of the queue head.
REQ-013 if_inst  output  32: instruction word of the queue head.

Function
REQ-014 The block SHALL contain a state machine with states IDLE, RUN and HOLD.
- IDLE: entered on reset; rom_ce=0; goes to RUN on the first clock edge after reset release.
- RUN: rom_ce=1.
- HOLD: queue full; rom_ce=0.
REQ-015 rom_addr SHALL equal the fetch PC register at all times, with bits [1:0] always 2'b00.
REQ-016 push: at the clock edge, push SHALL be true when rom_ce=1, branch_flag=0 and the queue is not full after this cycle's pop. On push, {rom_addr, rom_inst} SHALL be written to the queue tail and the fetch PC SHALL advance by 4.
REQ-017 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-018 pop: pop SHALL occur when if_valid=1 and stall=0; the head is removed at the clock edge.
REQ-019 if_valid/if_pc/if_inst SHALL be driven from the registered queue head, with no combinational path from rom_inst.
- When the queue is empty: if_valid=0, if_pc=0, if_inst=0.
REQ-020 Latency: an instruction fetched in cycle n SHALL appear on if_* in cycle n+1 if the queue was empty.
REQ-021 Queue ordering SHALL be strict program order; simultaneous push and pop on a full queue SHALL NOT occur (HOLD blocks it).
REQ-022 State transitions:
- RUN->HOLD when the queue count becomes QDEPTH after the edge.
- HOLD->RUN when a pop occurs.
- In HOLD, rom_ce stays 0 during the popping cycle; the fetch resumes the next cycle.
REQ-023 Redirect: branch_flag=1 at an edge SHALL:
- flush all queue entries;
- load the fetch PC with {branch_target_address[31:2], 2'b00};
- suppress that cycle's push;
- enter RUN from RUN or HOLD.
REQ-024 Redirect priority: branch_flag SHALL take priority over stall, push and pop in the same cycle; the head's pop is discarded with the flush.
REQ-025 After a redirect, if_valid SHALL be 0 for exactly one cycle, then present the target instruction, provided the ROM is enabled.
REQ-026 branch_flag in IDLE SHALL update the fetch PC; IDLE->RUN proceeds normally.

Reset
REQ-027 While rst=0, outputs SHALL be: rom_ce=0, rom_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
REQ-028 While rst=0, internal state SHALL be: queue count=0, state=IDLE.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronous), with no partial push retained.

Structure
REQ-030 Constants SHALL live in the shared defines file:
- IF state encodings;
- ZeroWord;
- ChipEnable/ChipDisable;
- InstAddrBus/InstBus widths.
REQ-031 The queue SHALL be a sub-module fetch_queue (parameterized depth, {pc,inst} payload, push/pop/flush, count output); the FSM and PC SHALL remain in if_fetch.

Verification
REQ-032 Reset release, stall=0, ROM preloaded with word(addr)=addr^32'hA5A5_0000 -> rom_ce rises 1 cycle after release; if_pc sequence 0,4,8,… on consecutive cycles; if_inst matches.
REQ-033 stall=1 held 5 cycles from if_pc=8 -> queue fills (QDEPTH=2: pc 8,12), rom_ce=0 in HOLD, if_pc held at 8. Release -> if_pc 8,12,16 in order, no gap after the first resume bubble.
REQ-034 branch_flag=1, target 32'h0000_0102, while stall=1 and queue full -> next cycle if_valid=0, rom_addr=32'h0000_0100; following cycle if_pc=32'h100.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst driven low asynchronously between edges while the queue holds 2 entries -> if_valid and rom_ce drop without waiting for clk; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the fetch state encodings, bus widths and the queue entry layout.
package if_fetch_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstBus     = 32;

   localparam logic [InstBus-1:0] ZeroWord    = '0;
   localparam logic               ChipEnable  = 1'b1;
   localparam logic               ChipDisable = 1'b0;

   typedef enum logic [1:0] {
      IfIdle = 2'b00,
      IfRun  = 2'b01,
      IfHold = 2'b10
   } if_state_e;

   typedef struct packed {
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, inst} pairs between the ROM and decode.
// Flush empties the queue in one cycle and outranks push/pop.
module fetch_queue
   import if_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  fetch_entry_t                   wr_data,
   output fetch_entry_t                   rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   fetch_entry_t    mem_q [DEPTH];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset; emptiness is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC, IDLE/RUN/HOLD control and ROM interface.
// Fetched words are buffered in fetch_queue; decode sees only the registered head.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned            QDEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   branch_flag,
   input  logic [InstAddrBus-1:0] branch_target_address,
   input  logic [InstBus-1:0]     rom_inst,
   output logic                   rom_ce,
   output logic [InstAddrBus-1:0] rom_addr,
   output logic                   if_valid,
   output logic [InstAddrBus-1:0] if_pc,
   output logic [InstBus-1:0]     if_inst
);

   localparam int unsigned            CntW      = $clog2(QDEPTH + 1);
   localparam logic [InstAddrBus-1:0] AlignMask = ~32'h0000_0003;

   if_state_e              state_q, state_d;
   logic [InstAddrBus-1:0] pc_q, pc_d;
   logic [CntW-1:0]        count, count_after_pop, count_next;
   logic                   push, pop;
   fetch_entry_t           head, tail;

   assign if_valid        = (count != '0);
   assign pop             = if_valid && !stall;
   assign count_after_pop = count - CntW'(pop);
   assign push            = (rom_ce == ChipEnable) && !branch_flag
                            && (count_after_pop < CntW'(QDEPTH));
   assign count_next      = count_after_pop + CntW'(push);

   assign rom_ce   = (state_q == IfRun) ? ChipEnable : ChipDisable;
   assign rom_addr = pc_q & AlignMask;

   always_comb begin
      pc_d = pc_q;
      if (branch_flag) begin
         pc_d = branch_target_address & AlignMask;
      end else if (push) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IfIdle: state_d = IfRun;
         IfRun: begin
            if (!branch_flag && (count_next == CntW'(QDEPTH))) state_d = IfHold;
         end
         // Fetch stays off in the popping cycle and resumes on the next one.
         IfHold: begin
            if (branch_flag || pop) state_d = IfRun;
         end
         default: state_d = IfIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IfIdle;
         pc_q    <= RESET_PC & AlignMask;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign tail.pc   = rom_addr;
   assign tail.inst = rom_inst;

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop && !branch_flag),
      .flush   (branch_flag),
      .wr_data (tail),
      .rd_data (head),
      .count   (count)
   );

   assign if_pc   = if_valid ? head.pc   : ZeroWord;
   assign if_inst = if_valid ? head.inst : ZeroWord;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: one default instance plus one with a wrapping
// reset PC and a four-entry queue, both fed by an address-derived ROM.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, stall2;
   logic        branch_flag;
   logic [31:0] bta;
   logic [31:0] rom_inst, rom_inst2;
   logic        rom_ce, rom_ce2;
   logic [31:0] rom_addr, rom_addr2;
   logic        if_valid, if_valid2;
   logic [31:0] if_pc, if_pc2;
   logic [31:0] if_inst, if_inst2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_inst  = rom_addr  ^ 32'hA5A5_0000;
   assign rom_inst2 = rom_addr2 ^ 32'hA5A5_0000;

   if_fetch dut (
      .clk                   (clk),
      .rst                   (rst),
      .stall                 (stall),
      .branch_flag           (branch_flag),
      .branch_target_address (bta),
      .rom_inst              (rom_inst),
      .rom_ce                (rom_ce),
      .rom_addr              (rom_addr),
      .if_valid              (if_valid),
      .if_pc                 (if_pc),
      .if_inst               (if_inst)
   );

   if_fetch #(
      .RESET_PC (32'hFFFF_FFF8),
      .QDEPTH   (4)
   ) dut2 (
      .clk                   (clk),
      .rst                   (rst),
      .stall                 (stall2),
      .branch_flag           (1'b0),
      .branch_target_address (32'h0000_0000),
      .rom_inst              (rom_inst2),
      .rom_ce                (rom_ce2),
      .rom_addr              (rom_addr2),
      .if_valid              (if_valid2),
      .if_pc                 (if_pc2),
      .if_inst               (if_inst2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; stall = 1'b0; stall2 = 1'b0; branch_flag = 1'b0; bta = '0;
      repeat (2) @(negedge clk);
      chk("rst_ce",    32'(rom_ce),   32'h0);
      chk("rst_addr",  rom_addr,      32'h0);
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_pc",    if_pc,         32'h0);
      chk("rst_inst",  if_inst,       32'h0);
      chk("rst_addr2", rom_addr2,     32'hFFFF_FFF8);
      rst = 1'b1;

      @(negedge clk); // IDLE -> RUN
      chk("ce_rise",     32'(rom_ce),   32'h1);
      chk("first_addr",  rom_addr,      32'h0);
      chk("first_empty", 32'(if_valid), 32'h0);
      chk("ce_rise2",    32'(rom_ce2),  32'h1);

      @(negedge clk);
      chk("seq0_valid", 32'(if_valid), 32'h1);
      chk("seq0_pc",    if_pc,         32'h0);
      chk("seq0_inst",  if_inst,       32'hA5A5_0000);
      chk("wrap0_pc",   if_pc2,        32'hFFFF_FFF8);
      chk("wrap0_inst", if_inst2,      32'h5A5A_FFF8);

      @(negedge clk);
      chk("seq1_pc",   if_pc,   32'h4);
      chk("seq1_inst", if_inst, 32'hA5A5_0004);
      chk("wrap1_pc",  if_pc2,  32'hFFFF_FFFC);

      @(negedge clk);
      chk("seq2_pc",    if_pc,    32'h8);
      chk("seq2_inst",  if_inst,  32'hA5A5_0008);
      chk("wrap2_pc",   if_pc2,   32'h0);
      chk("wrap2_inst", if_inst2, 32'hA5A5_0000);
      stall = 1'b1; stall2 = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_pc",    if_pc,         32'h8);
         chk("hold_ce",    32'(rom_ce),   32'h0);
         chk("hold_valid", 32'(if_valid), 32'h1);
         chk("d4_pc",      if_pc2,        32'h0);
         if (i == 1) chk("d4_fill_ce", 32'(rom_ce2), 32'h1);
         if (i == 2) chk("d4_hold_ce", 32'(rom_ce2), 32'h0);
      end
      stall = 1'b0; stall2 = 1'b0;

      @(negedge clk);
      chk("resume_pc",   if_pc,        32'hC);
      chk("resume_ce",   32'(rom_ce),  32'h1);
      chk("resume_addr", rom_addr,     32'h10);
      chk("d4_resume",   if_pc2,       32'h4);
      chk("d4_addr",     rom_addr2,    32'h10);

      @(negedge clk);
      chk("resume2_pc", if_pc,  32'h10);
      chk("d4_next",    if_pc2, 32'h8);
      stall = 1'b1;

      @(negedge clk);
      chk("full_ce", 32'(rom_ce), 32'h0);
      chk("full_pc", if_pc,       32'h10);
      branch_flag = 1'b1; bta = 32'h0000_0102;

      @(negedge clk);
      chk("br_valid", 32'(if_valid), 32'h0);
      chk("br_addr",  rom_addr,      32'h100);
      chk("br_ce",    32'(rom_ce),   32'h1);
      chk("br_pc",    if_pc,         32'h0);
      branch_flag = 1'b0; stall = 1'b0;

      @(negedge clk);
      chk("tgt_pc",   if_pc,   32'h100);
      chk("tgt_inst", if_inst, 32'hA5A5_0100);
      stall = 1'b1;

      @(negedge clk);
      chk("two_valid", 32'(if_valid), 32'h1);
      chk("two_pc",    if_pc,         32'h100);
      chk("pre_ce2",   32'(rom_ce2),  32'h1);

      #2 rst = 1'b0;
      #1;
      chk("async_valid",  32'(if_valid),  32'h0);
      chk("async_ce",     32'(rom_ce),    32'h0);
      chk("async_pc",     if_pc,          32'h0);
      chk("async_addr",   rom_addr,       32'h0);
      chk("async_ce2",    32'(rom_ce2),   32'h0);
      chk("async_valid2", 32'(if_valid2), 32'h0);

      @(negedge clk);
      rst = 1'b1; stall = 1'b0;

      @(negedge clk);
      chk("restart_ce",    32'(rom_ce),   32'h1);
      chk("restart_addr",  rom_addr,      32'h0);
      chk("restart_empty", 32'(if_valid), 32'h0);

      @(negedge clk);
      chk("restart_pc",  if_pc,  32'h0);
      chk("restart_pc2", if_pc2, 32'hFFFF_FFF8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
